// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes,
// FSM state encoding and the default operand width.
package muldiv_pkg;

  localparam int MD_WIDTH = 32;

  localparam logic [1:0] MD_MULT  = 2'd0;
  localparam logic [1:0] MD_MULTU = 2'd1;
  localparam logic [1:0] MD_DIV   = 2'd2;
  localparam logic [1:0] MD_DIVU  = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } md_state_e;

endpackage

// File: rtl/muldiv_abs.sv
// Conditional two's-complement negate: y = neg ? -a : a.
module muldiv_abs #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic             neg,
  output logic [WIDTH-1:0] y
);

  assign y = neg ? (~a + WIDTH'(1)) : a;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit: one bit per cycle over a shared
// 2W-bit accumulator, results presented as hi/lo after sign correction.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  md_state_e          state, state_next;
  logic [2*WIDTH-1:0] acc, acc_next;
  logic [WIDTH-1:0]   divisor;
  logic [CW-1:0]      cnt;
  logic               is_div, neg_main, neg_rem;
  logic               last_step;

  // Operand conditioning. A zero divisor forces the unsigned path so the
  // raw quotient (all ones) and remainder (original rs) fall out naturally.
  logic             signed_op, sign_rs, sign_rt;
  logic [WIDTH-1:0] rs_mag, rt_mag;

  assign signed_op = ~op[0] & ~(op[1] & (rt == '0));
  assign sign_rs   = signed_op & rs[WIDTH-1];
  assign sign_rt   = signed_op & rt[WIDTH-1];

  muldiv_abs #(.WIDTH(WIDTH)) u_abs_rs (.a(rs), .neg(sign_rs), .y(rs_mag));
  muldiv_abs #(.WIDTH(WIDTH)) u_abs_rt (.a(rt), .neg(sign_rt), .y(rt_mag));

  // One iteration. The low half of acc starts as multiplier/dividend and is
  // shifted out as product/quotient bits are shifted in.
  logic [WIDTH:0]     mul_sum, div_shift, div_trial;
  logic [2*WIDTH-1:0] mul_next, div_next;

  assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? divisor : '0)};
  assign mul_next  = {mul_sum, acc[WIDTH-1:1]};
  assign div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign div_trial = div_shift - {1'b0, divisor};
  assign div_next  = div_trial[WIDTH]
                   ? {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                   : {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
  assign acc_next  = is_div ? div_next : mul_next;

  // Sign correction applied to the final iteration's value.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix, res_hi, res_lo;

  muldiv_abs #(.WIDTH(2*WIDTH)) u_abs_prod (.a(acc_next), .neg(neg_main), .y(prod_fix));
  muldiv_abs #(.WIDTH(WIDTH)) u_abs_quo (.a(acc_next[WIDTH-1:0]), .neg(neg_main), .y(quo_fix));
  muldiv_abs #(.WIDTH(WIDTH)) u_abs_rem (.a(acc_next[2*WIDTH-1:WIDTH]), .neg(neg_rem), .y(rem_fix));

  assign res_hi    = is_div ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
  assign res_lo    = is_div ? quo_fix : prod_fix[WIDTH-1:0];
  assign last_step = (cnt == CW'(WIDTH - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path
  // through the case can infer a latch.
  always_comb begin
    state_next = state;
    busy       = (state != IDLE);
    done       = (state == DONE);
    case (state)
      IDLE:    if (start) state_next = CALC;
      CALC:    if (last_step) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc      <= '0;
      divisor  <= '0;
      cnt      <= '0;
      is_div   <= 1'b0;
      neg_main <= 1'b0;
      neg_rem  <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            is_div   <= op[1];
            neg_main <= sign_rs ^ sign_rt;
            neg_rem  <= sign_rs;
            divisor  <= rt_mag;
            acc      <= {{WIDTH{1'b0}}, rs_mag};
            cnt      <= '0;
          end
        end
        CALC: begin
          acc <= acc_next;
          cnt <= cnt + CW'(1);
          if (last_step) begin
            hi <= res_hi;
            lo <= res_lo;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus random
// operations scored against an arithmetic reference model.
module tb_muldiv_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   op = 2'd0;
  logic [W-1:0] rs = '0;
  logic [W-1:0] rt = '0;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] exp_q[$];
  logic [63:0] held = '0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .rs(rs), .rt(rt), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: {hi, lo} from plain 64-bit arithmetic.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ax, bx;
    int          q, r;
    case (o)
      2'd0: begin
        ax = {{32{a[31]}}, a};
        bx = {{32{b[31]}}, b};
        return ax * bx;
      end
      2'd1: begin
        ax = {32'd0, a};
        bx = {32'd0, b};
        return ax * bx;
      end
      2'd2: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        return {r, q};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // Compare process: results on done, held values on every idle cycle.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      held = '0;
    end else if (done) begin
      if (exp_q.size() == 0) begin
        check("done_without_request", 64'(exp_q.size()), 64'd1);
      end else begin
        held = exp_q.pop_front();
        check("result", {hi, lo}, held);
      end
    end else if (!busy) begin
      check("hold", {hi, lo}, held);
    end
  end

  // Runs one op; checks busy/done timing each cycle; optionally pulses start
  // in cycle 5 and in the DONE cycle, both of which must be ignored.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit pulse, output logic [31:0] rh, output logic [31:0] rl);
    rh = '0;
    rl = '0;
    @(negedge clk);
    op = o; rs = a; rt = b; start = 1'b1;
    exp_q.push_back(model(o, a, b));
    for (int k = 1; k <= W + 2; k++) begin
      @(negedge clk);
      start = pulse && (k == 5 || k == W + 1);
      rs = $urandom;
      rt = $urandom;
      op = 2'($urandom_range(0, 3));
      check($sformatf("busy_c%0d", k), 64'(busy), 64'(k <= W + 1));
      check($sformatf("done_c%0d", k), 64'(done), 64'(k == W + 1));
      if (k == W + 1) begin
        rh = hi;
        rl = lo;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rh, rl, a, b;
    logic [1:0]  o;
    int          sel;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);

    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, rh, rl);
    check("multu_max", {rh, rl}, 64'hFFFF_FFFE_0000_0001);
    run_op(2'd0, -32'sd3, 32'd5, 1'b0, rh, rl);
    check("mult_neg3x5", {rh, rl}, 64'hFFFF_FFFF_FFFF_FFF1);
    run_op(2'd0, 32'h8000_0000, 32'h8000_0000, 1'b0, rh, rl);
    check("mult_minxmin", {rh, rl}, 64'h4000_0000_0000_0000);
    run_op(2'd3, 32'd100, 32'd7, 1'b0, rh, rl);
    check("divu_100_7", {rh, rl}, {32'd2, 32'd14});
    run_op(2'd2, -32'sd7, 32'd2, 1'b0, rh, rl);
    check("div_m7_2", {rh, rl}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(2'd2, 32'd7, -32'sd2, 1'b0, rh, rl);
    check("div_7_m2", {rh, rl}, {32'd1, 32'hFFFF_FFFD});
    run_op(2'd2, 32'h1234, 32'd0, 1'b0, rh, rl);
    check("div_by_zero", {rh, rl}, {32'h1234, 32'hFFFF_FFFF});
    run_op(2'd3, 32'h1234, 32'd0, 1'b0, rh, rl);
    check("divu_by_zero", {rh, rl}, {32'h1234, 32'hFFFF_FFFF});
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, rh, rl);
    check("div_overflow", {rh, rl}, {32'd0, 32'h8000_0000});
    run_op(2'd2, 32'hFFFF_FF00, 32'd0, 1'b0, rh, rl);
    check("div_neg_by_zero", {rh, rl}, {32'hFFFF_FF00, 32'hFFFF_FFFF});

    // start pulses while busy are ignored; result holds while inputs toggle
    run_op(2'd3, 32'd1000, 32'd33, 1'b1, rh, rl);
    check("divu_ignored_start", {rh, rl}, {32'd10, 32'd30});
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      rs = $urandom;
      rt = $urandom;
      check("idle_busy", 64'(busy), 64'd0);
      check("idle_hold", {hi, lo}, {32'd10, 32'd30});
    end

    // asynchronous reset in the middle of a DIV
    @(negedge clk);
    op = 2'd2; rs = 32'h7654_3210; rt = 32'd3; start = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    #2 rst = 1'b1;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_done", 64'(done), 64'd0);
    check("arst_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (W + 4) begin
      @(negedge clk);
      check("post_reset_no_done", 64'(done), 64'd0);
    end
    run_op(2'd1, 32'd6, 32'd7, 1'b0, rh, rl);
    check("multu_6x7", {rh, rl}, 64'd42);

    for (int i = 0; i < 60; i++) begin
      o = 2'($urandom_range(0, 3));
      sel = $urandom_range(0, 7);
      a = (sel == 0) ? 32'h8000_0000 : (sel == 1) ? 32'd0 : $urandom;
      sel = $urandom_range(0, 7);
      b = (sel == 0) ? 32'd0 : (sel == 1) ? 32'($urandom_range(1, 9)) :
          (sel == 2) ? 32'hFFFF_FFFF : $urandom;
      run_op(o, a, b, 1'b0, rh, rl);
    end

    repeat (3) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
